// File: rtl/adr_fifo_frame_buf_if.sv
// Handshake and status bundle for adr_fifo_frame_buf.
// The master drives requests; the slave (the FIFO) drives data and status.
interface adr_fifo_frame_buf_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
);
  logic             wr;
  logic [WIDTH-1:0] w_data;
  logic             rd;
  logic             commit;
  logic             abort;
  logic [WIDTH-1:0] r_data;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [DEPTH:0]   count;
  logic [DEPTH:0]   space;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, w_data, rd, commit, abort,
    input  r_data, empty, full, almost_empty, almost_full, count, space, overflow, underflow
  );

  modport slave (
    input  wr, w_data, rd, commit, abort,
    output r_data, empty, full, almost_empty, almost_full, count, space, overflow, underflow
  );
endinterface

// File: rtl/adr_fifo_frame_buf.sv
// Synchronous FWFT FIFO with registered occupancy/threshold flags and error pulses.
// Define ADR_FIFO_COMMIT_EN to hold writes pending until commit (abort discards them).
module adr_fifo_frame_buf #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 3,
  parameter int AF_THRESH = 2**DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input logic                 clk,
  input logic                 reset,
  adr_fifo_frame_buf_if.slave bus
);
  localparam int             N    = 2**DEPTH;
  localparam logic [DEPTH:0] N_V  = (DEPTH+1)'(N);
  localparam logic [DEPTH:0] AF_T = (DEPTH+1)'(AF_THRESH);
  localparam logic [DEPTH:0] AE_T = (DEPTH+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [N];
  logic [DEPTH-1:0] w_ptr, r_ptr, w_ptr_n, r_ptr_n;
  logic [DEPTH:0]   cnt, pend, cnt_n, pend_n, tot_n;
  logic [DEPTH:0]   space_q;
  logic             empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
  logic             rd_ok, wr_ok;

  // A read at full frees the slot the write lands in, so it may proceed.
  assign rd_ok   = bus.rd & ~empty_q;
  assign wr_ok   = bus.wr & (~full_q | rd_ok);
  assign r_ptr_n = r_ptr + DEPTH'(rd_ok);

`ifdef ADR_FIFO_COMMIT_EN
  logic [DEPTH-1:0] c_ptr, c_ptr_n;

  always_comb begin
    w_ptr_n = w_ptr + DEPTH'(wr_ok);
    cnt_n   = cnt - (DEPTH+1)'(rd_ok);
    pend_n  = pend + (DEPTH+1)'(wr_ok);
    c_ptr_n = c_ptr;
    if (bus.abort) begin
      pend_n  = '0;
      w_ptr_n = c_ptr;
    end else if (bus.commit) begin
      cnt_n   = cnt_n + pend_n;
      pend_n  = '0;
      c_ptr_n = w_ptr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) c_ptr <= '0;
    else       c_ptr <= c_ptr_n;
  end
`else
  logic unused_ctl;
  assign unused_ctl = bus.commit ^ bus.abort;

  always_comb begin
    w_ptr_n = w_ptr + DEPTH'(wr_ok);
    cnt_n   = cnt + (DEPTH+1)'(wr_ok) - (DEPTH+1)'(rd_ok);
    pend_n  = '0;
  end
`endif

  assign tot_n = cnt_n + pend_n;

  // Flags are registered from next-state counts so they never lag the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      cnt     <= '0;
      pend    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= (AF_T == '0);
      space_q <= N_V;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr   <= w_ptr_n;
      r_ptr   <= r_ptr_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      empty_q <= (cnt_n == '0);
      full_q  <= (tot_n == N_V);
      ae_q    <= (cnt_n <= AE_T);
      af_q    <= (tot_n >= AF_T);
      space_q <= N_V - tot_n;
      ovf_q   <= bus.wr & ~wr_ok;
      udf_q   <= bus.rd & ~rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[w_ptr] <= bus.w_data;
  end

  assign bus.r_data       = mem[r_ptr];
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.count        = cnt;
  assign bus.space        = space_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_adr_fifo_frame_buf.sv
// Randomized and directed bench for adr_fifo_frame_buf against a queue-based model.
// Honours ADR_FIFO_COMMIT_EN the same way the design does.
module tb_adr_fifo_frame_buf;
  localparam int W = 64;
  localparam int D = 3;
  localparam int N = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adr_fifo_frame_buf_if #(.WIDTH(W), .DEPTH(D)) bus ();

  adr_fifo_frame_buf #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] cq[$];
  logic [W-1:0] pq[$];
  bit m_ovf, m_udf;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed words in cq, pending words in pq.
  task automatic model_edge(input bit w, input bit r, input logic [W-1:0] d, input bit cm, input bit ab);
    bit rok, wok;
    if (reset) begin
      cq.delete(); pq.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      rok = r && (cq.size() > 0);
      wok = w && ((cq.size() + pq.size() < N) || rok);
      m_ovf = w && !wok;
      m_udf = r && !rok;
      if (rok) void'(cq.pop_front());
`ifdef ADR_FIFO_COMMIT_EN
      if (wok) pq.push_back(d);
      if (ab) pq.delete();
      else if (cm) begin
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
      end
`else
      if (wok) cq.push_back(d);
      if (cm || ab) begin end
`endif
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input bit cm = 0, input bit ab = 0);
    bus.wr = w; bus.rd = r; bus.w_data = d; bus.commit = cm; bus.abort = ab;
    @(posedge clk);
    model_edge(w, r, d, cm, ab);
    #1;
  endtask

  always @(negedge clk) begin
    int c, t;
    if (chk_en) begin
      c = cq.size();
      t = c + pq.size();
      chk("empty", 64'(bus.empty), 64'(c == 0));
      chk("full", 64'(bus.full), 64'(t == N));
      chk("almost_empty", 64'(bus.almost_empty), 64'(c <= AE));
      chk("almost_full", 64'(bus.almost_full), 64'(t >= AF));
      chk("count", 64'(bus.count), 64'(c));
      chk("space", 64'(bus.space), 64'(N - t));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("underflow", 64'(bus.underflow), 64'(m_udf));
      if (c > 0) chk("r_data", bus.r_data, cq[0]);
    end
  end

  initial begin
    int wb, rb;
    bus.wr = 0; bus.rd = 0; bus.w_data = '0; bus.commit = 0; bus.abort = 0;
    reset = 1;
    step(0, 0, 0);
    chk_en = 1;
    chk("rst_empty", 64'(bus.empty), 1);
    chk("rst_ae", 64'(bus.almost_empty), 1);
    chk("rst_full", 64'(bus.full), 0);
    chk("rst_af", 64'(bus.almost_full), 0);
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_space", 64'(bus.space), 8);
    reset = 0;

    // Fill with self-committing writes (commit is a no-op without the macro).
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 64'(100 + i), 1);
      if (i == 0) chk("ae_at1", 64'(bus.almost_empty), 1);
      if (i == 1) chk("ae_at2", 64'(bus.almost_empty), 0);
      if (i == 4) chk("af_at5", 64'(bus.almost_full), 0);
      if (i == 5) chk("af_at6", 64'(bus.almost_full), 1);
    end
    chk("fill_full", 64'(bus.full), 1);
    chk("fill_count", 64'(bus.count), 8);
    chk("fill_space", 64'(bus.space), 0);
    step(1, 0, 64'd999, 1);
    chk("ovf_9th", 64'(bus.overflow), 1);
    step(1, 1, 64'd200, 1);
    chk("full_rw_ovf", 64'(bus.overflow), 0);
    chk("full_rw_count", 64'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", bus.r_data, (i == 7) ? 64'd200 : 64'(101 + i));
      step(0, 1, 0);
    end
    chk("drain_empty", 64'(bus.empty), 1);
    step(0, 1, 0);
    chk("udf_9th", 64'(bus.underflow), 1);

    step(1, 1, 64'hABC, 1);
    chk("empty_rw_udf", 64'(bus.underflow), 1);
    chk("empty_rw_empty", 64'(bus.empty), 0);
    chk("empty_rw_count", 64'(bus.count), 1);
    chk("empty_rw_data", bus.r_data, 64'hABC);
    step(0, 1, 0);

`ifdef ADR_FIFO_COMMIT_EN
    for (int i = 0; i < 3; i++) step(1, 0, 64'(10 + i));
    chk("cm_empty", 64'(bus.empty), 1);
    chk("cm_count0", 64'(bus.count), 0);
    chk("cm_space", 64'(bus.space), 5);
    step(0, 0, 0, 1);
    chk("cm_count3", 64'(bus.count), 3);
    step(1, 0, 64'd50);
    step(1, 0, 64'd51);
    step(0, 0, 0, 0, 1);
    chk("ab_space", 64'(bus.space), 5);
    for (int i = 0; i < 3; i++) begin
      chk("ab_data", bus.r_data, 64'(10 + i));
      step(0, 1, 0);
    end
    chk("ab_empty", 64'(bus.empty), 1);
`endif

    // Reset mid-frame: 5 committed, 2 written without commit.
    for (int i = 0; i < 5; i++) step(1, 0, 64'(30 + i), 1);
    step(1, 0, 64'd40);
    step(1, 0, 64'd41);
    reset = 1;
    step(0, 0, 0);
    chk("mrst_count", 64'(bus.count), 0);
    chk("mrst_space", 64'(bus.space), 8);
    chk("mrst_empty", 64'(bus.empty), 1);
    reset = 0;
    step(1, 0, 64'h55, 1);
    chk("mrst_rt_data", bus.r_data, 64'h55);
    chk("mrst_rt_count", 64'(bus.count), 1);
    step(0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      wb = ((i / 60) % 2) ? 80 : 30;
      rb = ((i / 60) % 2) ? 30 : 75;
      reset = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, {$urandom, $urandom},
           $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
    end
    reset = 0;
    step(0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adr_fifo_frame_buf.md
# adr_fifo_frame_buf

Parametrised synchronous FIFO for the buffer datapath. It is the successor to the basic single-clock FIFO and adds:
- exact registered occupancy and space counts;
- programmable almost-full and almost-empty thresholds;
- defined simultaneous read/write behaviour at full and at empty;
- overflow and underflow error pulses;
- optional frame commit/abort, so a partially written frame can be discarded before the reader sees it.

## Interface
Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 3, log2 of entry count; the FIFO holds 2**DEPTH words.
- AF_THRESH, 2**DEPTH-2, almost_full asserts when total occupancy >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when committed occupancy <= AE_THRESH.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- w_data  in  WIDTH  write data.
- rd  in  1  read request; pops the word currently shown on r_data.
- commit  in  1  publishes all pending words to the read side (ignored without the macro).
- abort  in  1  discards all pending words (ignored without the macro).
- r_data  out  WIDTH  head word, first-word-fall-through; undefined when empty.
- empty  out  1  no committed words.
- full  out  1  total occupancy == 2**DEPTH.
- almost_empty  out  1  committed count <= AE_THRESH.
- almost_full  out  1  total occupancy >= AF_THRESH.
- count  out  DEPTH+1  committed words readable.
- space  out  DEPTH+1  2**DEPTH minus total occupancy (committed + pending).
- overflow  out  1  one-cycle pulse when a write is rejected.
- underflow  out  1  one-cycle pulse when a read is rejected.

## Operation
- Storage is a 2**DEPTH x WIDTH register array. The write pointer w_ptr, read pointer r_ptr and commit pointer c_ptr are DEPTH bits wide and wrap modulo 2**DEPTH.
- Occupancy is tracked with (DEPTH+1)-bit counters: committed count and pending count. Full/empty are never derived from pointer equality.
- Read accepted: rd & ~empty. Write accepted: wr & (~full | read accepted).
  - At full, a simultaneous read frees a slot, so the write is accepted and count stays at 2**DEPTH.
  - At empty, a simultaneous write does not satisfy the read: underflow pulses and the write is stored normally.
- Rejected write: overflow=1 for one cycle; no state change from the write.
- Rejected read: underflow=1 for one cycle; no state change from the read.
- Accepted write stores w_data at w_ptr, then w_ptr+1.
- Accepted read advances r_ptr; r_data then shows the next word.
- All flags, count and space are registered from next-state values, so they are consistent with each other in every cycle and show no one-cycle lag.
- Reset: pointers=0, counts=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>0), count=0, space=2**DEPTH, overflow=0, underflow=0. Array contents are not reset.
- Reset asserted mid-frame discards everything, including pending words.

## Timing
- Write-to-read latency is 1 cycle: a word written at edge N is on r_data, with empty=0, after edge N (commit mode: after the commit edge).
- Read latency is 0: r_data is combinational from array[r_ptr].
- count, space and all flags update at the same edge as the accepted operation.
- commit at edge N includes a write accepted at edge N; the word is readable after edge N.
- abort at edge N discards a write accepted at edge N and sets w_ptr to c_ptr. A read in the same cycle proceeds.
- commit & abort together: abort wins.

## Configuration
- Macro ADR_FIFO_COMMIT_EN.
- Defined: writes are pending until commit. empty, almost_empty, count and r_data reflect committed words only. full, almost_full and space reflect committed plus pending words.
- Undefined: commit and abort are ignored, every accepted write is committed immediately, pending count is always 0, and the port list is unchanged.

## Test plan
- Fill/drain, DEPTH=3: after 8 writes: full=1, count=8, space=0. 9th write: overflow pulse. 8 reads return data in order; empty=1, underflow on the 9th read.
- Simultaneous rd&wr at full: count stays 8, no overflow, the new word is returned as the 8th read after it.
- Simultaneous rd&wr at empty: underflow=1, next cycle empty=0, count=1, r_data=written word.
- Thresholds AF_THRESH=6, AE_THRESH=1: almost_full rises at the 6th write; almost_empty falls when count reaches 2.
- Commit (macro on): write 3, then empty=1, count=0, space=5. commit gives count=3. Write 2, abort: space returns to 5 and the reads return only the 3 committed words.
- Reset asserted with count=5 and 2 words pending: next cycle all outputs are at their reset values and a subsequent write/read round-trips correctly from pointer 0.
